// File: rtl/pool_vert2_if.sv
// rtl/pool_vert2_if.sv - beat stream in, pooled beat stream out for pool_vert2
interface pool_vert2_if #(
  parameter int DW = 8,
  parameter int DN = 6
);
  logic          i_sof;
  logic [DN*DW-1:0] i_data;
  logic          i_valid;
  logic [DN*DW-1:0] o_data;
  logic          o_valid;
  logic          o_last;

  modport master (
    output i_sof, i_data, i_valid,
    input  o_data, o_valid, o_last
  );

  modport slave (
    input  i_sof, i_data, i_valid,
    output o_data, o_valid, o_last
  );
endinterface

// File: rtl/pool_vert2.sv
// rtl/pool_vert2.sv - vertical 2x1 max-pool: buffers one row, merges with the next
// Define POOL_VERT2_SIGNED_EN to compare lanes as two's-complement values.
module pool_vert2 #(
  parameter int DW      = 8,
  parameter int DN      = 6,
  parameter int ROW_LEN = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  pool_vert2_if.slave  bus
);

  localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;

  logic [DN*DW-1:0] line_buf [ROW_LEN];
  logic [CW-1:0]    col;
  logic [0:0]       phase;
  logic [DN*DW-1:0] o_data_q;
  logic             o_valid_q;
  logic             o_last_q;

  logic             col_last;
  logic [DN*DW-1:0] rd_data;
  logic [DN*DW-1:0] max_data;
  logic [DW-1:0]    lane_a;
  logic [DW-1:0]    lane_b;
  logic             lane_ge;

  assign col_last = (col == CW'(ROW_LEN - 1));
  assign rd_data  = line_buf[col];

  always_comb begin
    max_data = '0;
    lane_a   = '0;
    lane_b   = '0;
    lane_ge  = 1'b0;
    for (int i = 0; i < DN; i++) begin
      lane_a = bus.i_data[i*DW +: DW];
      lane_b = rd_data[i*DW +: DW];
`ifdef POOL_VERT2_SIGNED_EN
      lane_ge = ($signed(lane_a) >= $signed(lane_b));
`else
      lane_ge = (lane_a >= lane_b);
`endif
      max_data[i*DW +: DW] = lane_ge ? lane_a : lane_b;
    end
  end

  // A sof beat always lands in slot 0, regardless of where the previous row stopped.
  always_ff @(posedge clk) begin
    if (bus.i_valid) begin
      if (bus.i_sof)
        line_buf[0] <= bus.i_data;
      else if (phase == FILL)
        line_buf[col] <= bus.i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      phase     <= FILL;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      if (bus.i_valid) begin
        if (bus.i_sof) begin
          col   <= CW'(1);
          phase <= FILL;
        end else begin
          col <= col_last ? '0 : col + CW'(1);
          if (col_last)
            phase <= ~phase;
          if (phase == MERGE) begin
            o_data_q  <= max_data;
            o_valid_q <= 1'b1;
            o_last_q  <= col_last;
          end
        end
      end
    end
  end

  assign bus.o_data  = o_data_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;

endmodule

// File: doc/pool_vert2.md
# pool_vert2

Vertical half of the 2×2 max-pool path. Sits directly downstream of the horizontal pair-compare stage: takes its stream of horizontally pooled beats (DN channels × DW bits), buffers one full row, compares it lane-by-lane with the next row, and emits one output row per two input rows. Output feeds the pooled-feature writeback.

## Interface
- DW, 8: bits per channel element.
- DN, 6: channels (lanes) per beat.
- ROW_LEN, 14: beats per input row (already horizontally pooled); ≥2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_sof  in  1  start of frame; qualifies with i_valid, marks beat as row 0 col 0.
- i_data  in  DN*DW  input beat, lane i at [i*DW +: DW].
- i_valid  in  1  input beat valid; no backpressure, every valid beat is consumed.
- o_data  out  DN*DW  pooled beat.
- o_valid  out  1  o_data valid, single-cycle per beat.
- o_last  out  1  asserted with o_valid on final beat of an output row.

## Operation
- Line buffer: ROW_LEN entries × DN*DW bits, register array or inferred RAM; not reset.
- col counter: width max(1,$clog2(ROW_LEN)), reset 0; increments on each i_valid, wraps ROW_LEN-1 → 0.
- phase FSM, 2 states: FILL (reset state) and MERGE.
  - FILL: valid beat written to buf[col]; no output. At col wrap → MERGE.
  - MERGE: valid beat compared lane-wise with buf[col]; result registered to o_data, o_valid=1. At col wrap → FILL.
- i_sof with i_valid: forces col=0, phase=FILL for that beat (beat written to buf[0]); col→1, phase stays FILL. Any partial row in progress is discarded, no output produced for it. i_sof without i_valid ignored.
- Compare: per lane, out = (a ≥ b) ? a : b, unsigned by default (see Configuration). Tie returns either; values identical.
- i_valid low: counters, phase, buffer hold; o_valid=0 next cycle.
- No state beyond buffer, col, phase, output registers.

## Timing
- Reset values: o_data=0, o_valid=0, o_last=0, col=0, phase=FILL.
- Latency: MERGE beat at cycle n → o_valid/o_data at cycle n+1 (one register).
- o_last=1 iff the output beat came from col=ROW_LEN-1 in MERGE.
- o_data holds last value when o_valid=0 (not cleared).
- Throughput: one beat per cycle sustained; back-to-back rows with no gap supported, including the FILL→MERGE edge (buf write at col k in FILL and read of col k in next row never collide in the same cycle).
- Reset asserted mid-row: all counters/outputs return to reset values immediately; first row after reset treated as FILL.
- Output rate: ROW_LEN beats per 2·ROW_LEN input beats.

## Configuration
- POOL_VERT2_SIGNED_EN defined: each lane compared as two's-complement signed DW-bit values.
- Not defined: lanes compared as unsigned. Must match setting of the horizontal compare stage for correct 2×2 max.

## Test plan
- Basic: ROW_LEN=4, DN=2, DW=8; row0 lanes {10,200},{1,2},{3,4},{5,6}; row1 {20,100},{0,9},{3,4},{7,1} → 4 outputs {20,200},{1,9},{3,4},{7,6}, o_last on 4th, each 1 cycle after its row1 beat.
- Gapped input: same stimulus with i_valid low on alternate cycles → identical output values, o_valid only one cycle after each row1 beat, no output during row0.
- Continuous frame: 4 rows back-to-back, ROW_LEN=4 → exactly 8 o_valid pulses, o_last on 4th and 8th, no bubble between row boundaries.
- Mid-row sof: 2 beats of row0, then i_sof beat → col restarts; subsequent 4+4 beats give 4 outputs; earlier partial row contributes nothing.
- Signed: with POOL_VERT2_SIGNED_EN, lanes 0x80 vs 0x01 → 0x01; without macro → 0x80.
- Reset mid-MERGE: assert rst_n low after 2 row1 beats → o_valid/o_data/o_last 0 immediately; next 4 beats produce no output (FILL).
